// File: rtl/key_expansion_seq_pkg.sv
// key_expansion_seq_pkg: shared AES byte/word/key types, key-schedule constants and GF(2^8) helpers
package key_expansion_seq_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3] word_t;
  typedef byte_t [0:15] key128_t;

  localparam logic [3:0] NR = 4'd10;
  localparam byte_t RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1; shared with MixColumns.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p, r;
    p = a;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r = b[i] ? r ^ p : r;
      p = xtime(p);
    end
    return r;
  endfunction

  // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the AES affine map.
  function automatic byte_t sbox(input byte_t x);
    byte_t p, v;
    p = x;
    v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      v = gf_mul(v, p);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/key_expansion_seq_subword.sv
// key_expansion_seq_subword: SubWord, four parallel S-box lookups on one 32-bit word
module key_expansion_seq_subword
  import key_expansion_seq_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign word_o[i] = sbox(word_i[i]);
  end

endmodule

// File: rtl/key_expansion_seq.sv
// key_expansion_seq: sequential AES-128 key schedule emitting rounds 0..10 with valid/ready
module key_expansion_seq
  import key_expansion_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  key128_t    key,
  output logic       rk_valid,
  input  logic       rk_ready,
  output key128_t    rk,
  output logic [3:0] rk_round,
  output logic       rk_last
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0] state_q, state_d;
  key128_t    w_q, w_d;
  logic [3:0] round_q, round_d;
  byte_t      rcon_q, rcon_d;
  word_t      rot_w, sub_w, temp_w, n0, n1, n2, n3;

  assign rot_w = {w_q[13], w_q[14], w_q[15], w_q[12]};

  key_expansion_seq_subword u_subword (
    .word_i(rot_w),
    .word_o(sub_w)
  );

  assign temp_w = sub_w ^ {rcon_q, 24'h000000};
  assign n0 = w_q[0:3] ^ temp_w;
  assign n1 = w_q[4:7] ^ n0;
  assign n2 = w_q[8:11] ^ n1;
  assign n3 = w_q[12:15] ^ n2;

  // Load a key in IDLE, advance one round per accepted beat in EMIT, hold otherwise.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    if (state_q == S_IDLE) begin
      if (key_valid) begin
        state_d = S_EMIT;
        w_d     = key;
        round_d = 4'd0;
        rcon_d  = RCON_INIT;
      end
    end else if (rk_ready) begin
      if (round_q == NR) begin
        state_d = S_IDLE;
      end else begin
        w_d     = {n0, n1, n2, n3};
        round_d = round_q + 4'd1;
        rcon_d  = xtime(rcon_q);
      end
    end
  end

  // State registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      round_q <= 4'd0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  assign key_ready = state_q == S_IDLE;
  assign rk_valid  = state_q == S_EMIT;
  assign rk        = w_q;
  assign rk_round  = round_q;
  assign rk_last   = rk_valid && round_q == NR;

endmodule
